// File: rtl/iir_sos_sched.sv
// Control sequencer for a time-shared biquad datapath: walks NCH channels x NSOS sections x 5 taps
// through one MAC, with write-back, done pulse and dropped-sample accounting.
module iir_sos_sched #(
    parameter int NSOS    = 6,
    parameter int NCH     = 2,
    parameter int MAC_LAT = 2,
    parameter int DROPW   = 16,
    localparam int NTAP   = 5,
    localparam int CAW    = $clog2(NSOS * NTAP),
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SOSW   = (NSOS > 1) ? $clog2(NSOS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dv_in,
    output logic             in_load,
    output logic             busy,
    output logic [CHW-1:0]   ch,
    output logic [SOSW-1:0]  sos,
    output logic [2:0]       tap,
    output logic [CAW-1:0]   coeff_addr,
    output logic             src_sel,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             state_we,
    output logic             dv_out,
    output logic             overrun,
    output logic [DROPW-1:0] drop_cnt
);

    localparam int WW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [SOSW-1:0]   sos_q, sos_d;
    logic [2:0]        tap_q, tap_d;
    logic [CAW-1:0]    addr_q, addr_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              overrun_q;
    logic [DROPW-1:0]  drop_q;
    logic              last_sos, last_ch, drop_now;

    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WB);
    assign in_load  = dv_in & en & ~busy;
    assign drop_now = dv_in & en & busy;
    assign last_sos = (sos_q == SOSW'(NSOS - 1));
    assign last_ch  = (ch_q == CHW'(NCH - 1));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        sos_d   = sos_q;
        tap_d   = tap_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE drops busy so a coincident dv_in restarts with no bubble
                if (in_load) begin
                    state_d = S_ISSUE;
                    ch_d    = '0;
                    sos_d   = '0;
                    tap_d   = '0;
                    addr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (tap_q == 3'd4) begin
                    // Pre-load next section base; wrap to 0 so the address never leaves the ROM
                    tap_d   = '0;
                    addr_d  = last_sos ? '0 : addr_q + 1'b1;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    tap_d  = tap_q + 3'd1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_q == WW'(MAC_LAT - 1)) state_d = S_WB;
                else                            wait_d  = wait_q + 1'b1;
            end
            S_WB: begin
                state_d = S_ISSUE;
                if (last_sos) begin
                    sos_d = '0;
                    if (last_ch) begin
                        ch_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    sos_d = sos_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            sos_q     <= '0;
            tap_q     <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            sos_q     <= sos_d;
            tap_q     <= tap_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            overrun_q <= drop_now;
            if (drop_now && (drop_q != {DROPW{1'b1}})) drop_q <= drop_q + 1'b1;
        end
    end

    assign ch         = ch_q;
    assign sos        = sos_q;
    assign tap        = tap_q;
    assign coeff_addr = addr_q;
    assign src_sel    = (sos_q == '0);
    assign mac_en     = (state_q == S_ISSUE);
    assign mac_clr    = (state_q == S_ISSUE) && (tap_q == 3'd0);
    assign state_we   = (state_q == S_WB);
    assign dv_out     = (state_q == S_DONE);
    assign overrun    = overrun_q;
    assign drop_cnt   = drop_q;

endmodule
